// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift-register counter with run-time mode, direction, enable,
// parallel load, wrap pulse and self-correction of illegal states.
module ring_johnson_counter #(
    parameter int unsigned       WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap,
    output logic             illegal
);

    if (WIDTH < 2) begin : g_bad_width
        $error("ring_johnson_counter: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] start_pat;
    logic [WIDTH-1:0] step_val;
    int unsigned      ones;
    int unsigned      trans;

    assign start_pat = mode ? '0 : RING_SEED;

    // Legality is judged against the mode the stored state was produced in.
    always_comb begin
        ones  = 0;
        trans = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + 32'(q_q[i]);
        end
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            trans = trans + 32'(q_q[i] ^ q_q[i+1]);
        end
        illegal = mode_q ? (trans > 1) : (ones != 1);
    end

    always_comb begin
        step_val = q_q;
        unique case ({mode_q, dir})
            2'b00: step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            2'b01: step_val = {q_q[0], q_q[WIDTH-1:1]};
            2'b10: step_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            2'b11: step_val = {~q_q[0], q_q[WIDTH-1:1]};
            default: step_val = q_q;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d    = load_val;
            mode_d = mode;
        end else if (mode != mode_q) begin
            // Mode switch restarts from the new seed; no step this cycle.
            q_d    = start_pat;
            mode_d = mode;
        end else if (en) begin
            if (illegal) begin
                q_d = start_pat;
            end else begin
                q_d    = step_val;
                wrap_d = (step_val == start_pat);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q    <= start_pat;
            mode_q <= mode;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign wrap = wrap_q;

endmodule
